cilantro_mem_arbiter: RTL and testbench
=======================================

Name: cilantro_mem_arbiter

Overview:
Single-port memory arbiter and sequencer for the cilantro RV core. It shares one memory port between the instruction-fetch unit (IF) and the load/store unit (LS). It allows one outstanding transaction at a time, gives LS priority over IF with a starvation guard, and reports a timeout if memory never responds. It sits between the core and the unified instruction/data memory.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIMIT, 4, max consecutive LS grants while IF is pending before IF is forced to win (1..15)
TIMEOUT, 64, cycles to wait in WAIT for mem_rvalid before an error response (2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (logic 0 = reset)
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted and captured
if_rvalid  out  1  one-cycle pulse: fetch response valid
if_rdata  out  DW  fetch data, valid with if_rvalid
if_err  out  1  timeout flag, valid with if_rvalid
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1 = store
ls_be  in  DW/8  byte enables
ls_addr  in  AW  data address
ls_wdata  in  DW  store data
ls_gnt  out  1  one-cycle pulse: LS request accepted
ls_rvalid  out  1  one-cycle pulse: LS response (load data or store ack)
ls_rdata  out  DW  load data; 0 for stores
ls_err  out  1  timeout flag, valid with ls_rvalid
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_be  out  DW/8  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_ready  in  1  memory accepts mem_req this cycle
mem_rvalid  in  1  memory response valid (reads and writes)
mem_rdata  in  DW  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; streak=0; timeout counter=0; owner=IF.
  - All outputs 0; latched address, data, we and be are 0.
  - Takes effect mid-transaction: the in-flight access is dropped and no response is delivered. A later mem_rvalid is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Arbitration is combinational on if_req and ls_req.
  - The winner's gnt is asserted in the same cycle.
  - The winner's fields are captured (IF: we=0, be=all-ones, wdata=0). Next state is ISSUE.
  - Neither request: stay in IDLE, both gnt=0.
- Priority:
  - LS wins if ls_req=1, unless if_req=1 and streak==STARVE_LIMIT, in which case IF wins.
  - IF-only request: IF wins.
- Streak counter:
  - On an LS grant with if_req=1: streak increments, saturating at STARVE_LIMIT.
  - On an LS grant with if_req=0: streak clears.
  - On an IF grant: streak clears.
- ISSUE:
  - mem_req=1 with the latched fields, held stable.
  - mem_ready=1: go to WAIT and clear the timeout counter. Otherwise stay; there is no timeout in ISSUE.
- WAIT:
  - mem_req=0. The timeout counter increments each cycle.
  - mem_rvalid=1: next cycle the owner's rvalid=1 (registered), rdata=mem_rdata (reads) or 0 (writes), err=0. State returns to IDLE in that same next cycle, so a new gnt may coincide with that rvalid pulse.
  - Counter reaches TIMEOUT-1 without mem_rvalid: next cycle the owner's rvalid=1, err=1, rdata=0, state IDLE.
  - If mem_rvalid arrives in the same cycle the counter hits TIMEOUT-1, the normal response wins (err=0).
- mem_rvalid in IDLE or ISSUE is spurious and ignored.
- rvalid, err and rdata are 0 whenever rvalid is low.
- Minimum latency:
  - gnt in cycle 0, mem_req in cycle 1.
  - With mem_ready in cycle 1 and mem_rvalid in cycle 2, the owner's rvalid is in cycle 3.
  - Back-to-back grants are spaced at least 3 cycles apart.
- Requesters may drop or change req after gnt; the latched fields are unaffected.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0; memory ready immediately, rvalid one cycle later with rdata=0x00100013 -> if_gnt in cycle 0, mem_req in cycle 1 with mem_addr=0x0 and mem_we=0, if_rvalid in cycle 3 with if_rdata=0x00100013 and if_err=0.
- Store: ls_req=1, ls_we=1, ls_addr=0x100, ls_be=4'b0011, ls_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; on ack, ls_rvalid=1 with ls_rdata=0.
- Contention/starvation: if_req and ls_req held high continuously, STARVE_LIMIT=4 -> grant order LS, LS, LS, LS, IF, LS…, with streak clearing after the IF grant.
- Backpressure and timeout: mem_ready low for 5 cycles, then high, then no mem_rvalid -> mem_req and fields stable for all 6 cycles; owner rvalid with err=1 and rdata=0 exactly TIMEOUT cycles after WAIT entry.
- Reset mid-transaction: rst=0 during WAIT, released, then a late mem_rvalid=1 -> no rvalid on either port, busy=0, state IDLE; the next if_req is granted normally.
- Spurious response: mem_rvalid=1 while in IDLE or ISSUE -> no rvalid output and no state change.

Source files
------------

// File: rtl/cilantro_mem_arbiter.sv
// Single-port memory arbiter/sequencer for the cilantro core: IF and LS share one
// memory port, one transaction in flight, LS priority with an IF starvation guard.
module cilantro_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  output logic            if_err,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            ls_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BW = DW/8;
  localparam logic [3:0] LIM  = 4'(STARVE_LIMIT);
  localparam logic [7:0] TLST = 8'(TIMEOUT-1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    streak, streak_nxt;
  logic [7:0]    tmo, tmo_nxt;
  logic          owner, owner_nxt;   // 1 = LS owns the in-flight access
  logic [AW-1:0] addr_q, addr_nxt;
  logic          we_q, we_nxt;
  logic [BW-1:0] be_q, be_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          rsp_vld, rsp_err, ls_win;
  logic [DW-1:0] rsp_data;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    tmo_nxt    = tmo;
    owner_nxt  = owner;
    addr_nxt   = addr_q;
    we_nxt     = we_q;
    be_nxt     = be_q;
    wdata_nxt  = wdata_q;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    rsp_vld    = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    ls_win     = ls_req && !(if_req && streak == LIM);
    case (state)
      S_IDLE: begin
        // gnt is combinational; gate it so reset really forces all outputs low
        if (rst) begin
          if (ls_win) begin
            ls_gnt     = 1'b1;
            owner_nxt  = 1'b1;
            addr_nxt   = ls_addr;
            we_nxt     = ls_we;
            be_nxt     = ls_be;
            wdata_nxt  = ls_wdata;
            streak_nxt = if_req ? ((streak == LIM) ? streak : streak + 4'd1) : 4'd0;
            state_nxt  = S_ISSUE;
          end else if (if_req) begin
            if_gnt     = 1'b1;
            owner_nxt  = 1'b0;
            addr_nxt   = if_addr;
            we_nxt     = 1'b0;
            be_nxt     = '1;
            wdata_nxt  = '0;
            streak_nxt = 4'd0;
            state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          tmo_nxt   = 8'd0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo + 8'd1;
        // a real response beats a timeout landing in the same cycle
        if (mem_rvalid) begin
          rsp_vld   = 1'b1;
          rsp_data  = we_q ? '0 : mem_rdata;
          state_nxt = S_IDLE;
        end else if (tmo == TLST) begin
          rsp_vld   = 1'b1;
          rsp_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      streak    <= '0;
      tmo       <= '0;
      owner     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      tmo       <= tmo_nxt;
      owner     <= owner_nxt;
      addr_q    <= addr_nxt;
      we_q      <= we_nxt;
      be_q      <= be_nxt;
      wdata_q   <= wdata_nxt;
      if_rvalid <= rsp_vld && !owner;
      if_rdata  <= (rsp_vld && !owner) ? rsp_data : '0;
      if_err    <= rsp_vld && !owner && rsp_err;
      ls_rvalid <= rsp_vld && owner;
      ls_rdata  <= (rsp_vld && owner) ? rsp_data : '0;
      ls_err    <= rsp_vld && owner && rsp_err;
    end
  end

  assign mem_req   = (state == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_cilantro_mem_arbiter.sv
// Directed bench for cilantro_mem_arbiter: fetch, store, starvation guard,
// backpressure, timeout, reset mid-flight and spurious responses.
module tb_cilantro_mem_arbiter;
  localparam int AW = 32, DW = 32, SL = 4, TO = 64;

  logic          clk = 1'b0, rst = 1'b0;
  logic          if_req = 1'b0, if_gnt, if_rvalid, if_err;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0, ls_gnt, ls_rvalid, ls_err;
  logic [3:0]    ls_be = '0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0, ls_rdata;
  logic          mem_req, mem_we, mem_ready = 1'b0, mem_rvalid = 1'b0, busy;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;

  int errors = 0, checks = 0;
  logic exp_ls [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  cilantro_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs are then changed 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, with a request asserted to show gnt stays low in reset
    if_req = 1'b1;
    #2;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rvalid", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    if_req = 1'b0;
    step();
    rst = 1'b1;
    step();

    // spurious response while IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("spur_idle_rv", {if_rvalid, ls_rvalid}, 0);
    chk("spur_idle_busy", busy, 0);

    // single fetch, minimum latency
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("f_if_gnt", if_gnt, 1);
    chk("f_ls_gnt", ls_gnt, 0);
    step();
    if_req = 1'b0; if_addr = 32'hFFFF_FFFC; mem_ready = 1'b1;
    #1;
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h0);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_be", mem_be, 4'hF);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0013;
    #1;
    chk("f_wait_req", mem_req, 0);
    chk("f_wait_busy", busy, 1);
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
    #1;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h0010_0013);
    chk("f_if_err", if_err, 0);
    chk("f_ls_rvalid", ls_rvalid, 0);
    chk("f_busy_idle", busy, 0);
    step();
    chk("f_rvalid_pulse", if_rvalid, 0);
    chk("f_rdata_zero", if_rdata, 0);

    // store; also a spurious mem_rvalid during ISSUE
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_be = 4'b0011; ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("s_ls_gnt", ls_gnt, 1);
    step();
    ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0; ls_be = '0; mem_rvalid = 1'b1;
    #1;
    chk("s_mem_req", mem_req, 1);
    chk("s_mem_we", mem_we, 1);
    chk("s_mem_be", mem_be, 4'b0011);
    chk("s_mem_addr", mem_addr, 32'h100);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("spur_issue_rv", ls_rvalid, 0);
    chk("spur_issue_req", mem_req, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0123;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("s_ls_rvalid", ls_rvalid, 1);
    chk("s_ls_rdata", ls_rdata, 0);
    chk("s_ls_err", ls_err, 0);
    chk("s_if_rvalid", if_rvalid, 0);

    // contention: both held, grants every 3 cycles: LS LS LS LS IF LS
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_addr = 32'h80;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_0000;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("c_ls_gnt%0d", g), ls_gnt, exp_ls[g]);
      chk($sformatf("c_if_gnt%0d", g), if_gnt, !exp_ls[g]);
      if (g > 0) chk($sformatf("c_rv%0d", g), {if_rvalid, ls_rvalid}, {!exp_ls[g-1], exp_ls[g-1]});
      step();
      chk($sformatf("c_gap%0d", g), {if_gnt, ls_gnt}, 0);
      step();
      step();
    end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("c_last_rv", ls_rvalid, 1);
    step();

    // backpressure then timeout on a load
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_be = 4'hF; mem_rdata = 32'h9999_9999;
    #1;
    chk("t_ls_gnt", ls_gnt, 1);
    step();
    ls_req = 1'b0; ls_addr = 32'h300;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == 5);
      #1;
      chk($sformatf("t_req%0d", c), mem_req, 1);
      chk($sformatf("t_addr%0d", c), mem_addr, 32'h200);
      step();
    end
    mem_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      chk($sformatf("t_wait%0d", k), {ls_rvalid, mem_req, busy}, 3'b001);
      step();
    end
    chk("t_ls_rvalid", ls_rvalid, 1);
    chk("t_ls_err", ls_err, 1);
    chk("t_ls_rdata", ls_rdata, 0);
    chk("t_busy", busy, 0);
    step();
    chk("t_err_pulse", {ls_rvalid, ls_err}, 0);

    // response in the same cycle the counter hits TIMEOUT-1: normal response wins
    if_req = 1'b1; if_addr = 32'h44;
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int k = 0; k < TO - 1; k++) step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("b_not_yet", if_rvalid, 0);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("b_if_rvalid", if_rvalid, 1);
    chk("b_if_err", if_err, 0);
    chk("b_if_rdata", if_rdata, 32'hCAFE_F00D);

    // reset during WAIT, then a late response
    if_req = 1'b1; if_addr = 32'h88;
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    chk("r_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("r_busy", busy, 0);
    chk("r_mem_addr", mem_addr, 0);
    step();
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("r_no_rv", {if_rvalid, ls_rvalid, if_err, ls_err}, 0);
    chk("r_idle", busy, 0);
    if_req = 1'b1; if_addr = 32'hC0;
    #1;
    chk("r_if_gnt", if_gnt, 1);
    step();
    if_req = 1'b0;
    #1;
    chk("r_mem_addr2", mem_addr, 32'hC0);
    chk("r_mem_req2", mem_req, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
